// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-request / FIFO-write bundle between producers, arbiter and FIFO.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          fifo_full;
  logic                          fifo_write_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  modport master (
    output req, req_data, fifo_full,
    input  ack, fifo_write_en, fifo_data_in, grant, busy
  );

  modport slave (
    input  req, req_data, fifo_full,
    output ack, fifo_write_en, fifo_data_in, grant, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating priority encoder: first requester at or after last+1, wrapping.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   pick,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter driving the single write port of a synchronous FIFO.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input logic                clk,
  input logic                reset,
  fifo_write_arbiter_if.slave bus
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [IDX_W-1:0]    pick;
  logic                pick_vld;
  logic                owner_req;
  logic                write;

  logic [NUM_REQ-1:0]    grant_c;
  logic [NUM_REQ-1:0]    ack_c;
  logic                  busy_c;
  logic                  write_en_c;
  logic [DATA_WIDTH-1:0] data_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (bus.req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  assign owner_req = bus.req[owner_q];
  // Reset gates the strobe so a beat presented during reset is never written.
  assign write = (state_q == GRANT) && owner_req && !bus.fifo_full && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (write) begin
          burst_d = burst_q + BURST_W'(1);
          if (burst_q == BURST_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_c    = '0;
    ack_c      = '0;
    busy_c     = 1'b0;
    write_en_c = 1'b0;
    data_c     = '0;
    if (state_q == GRANT && !reset) begin
      grant_c[owner_q] = 1'b1;
      busy_c           = 1'b1;
      if (write) begin
        write_en_c     = 1'b1;
        ack_c[owner_q] = 1'b1;
        data_c         = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.grant         = grant_c;
  assign bus.ack           = ack_c;
  assign bus.busy          = busy_c;
  assign bus.fifo_write_en = write_en_c;
  assign bus.fifo_data_in  = data_c;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a small queue standing in for the FIFO.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [DW-1:0] pdata [NR];

  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_data();
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = pdata[i];
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    bus.req_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '1;
    bus.req_data = '1;
    bus.fifo_full = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (bus.fifo_write_en !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", bus.fifo_write_en); end
    checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", bus.ack); end
    checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", bus.grant); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.fifo_data_in !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", bus.fifo_data_in); end
    reset = 1'b0;
    bus.req = '0;
    tick();
    @(negedge clk);
    checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b/%b exp=0000/0", bus.grant, bus.busy); end
    tick();
  endtask

  task automatic test_single_beat();
    pdata[1] = 8'hA5;
    drive_data();
    bus.req = 4'b0010;
    @(negedge clk);
    checks++; if (bus.fifo_write_en !== 1'b0) begin failures++; $display("FAIL sb_idle_we got=%b exp=0", bus.fifo_write_en); end
    tick();
    @(negedge clk);
    checks++; if (bus.grant !== 4'b0010) begin failures++; $display("FAIL sb_grant got=%b exp=0010", bus.grant); end
    checks++; if (bus.fifo_write_en !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", bus.fifo_write_en); end
    checks++; if (bus.fifo_data_in !== 8'hA5) begin failures++; $display("FAIL sb_data got=%h exp=a5", bus.fifo_data_in); end
    checks++; if (bus.ack !== 4'b0010) begin failures++; $display("FAIL sb_ack got=%b exp=0010", bus.ack); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL sb_busy got=%b exp=1", bus.busy); end
    tick();
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if (bus.fifo_write_en !== 1'b0 || bus.ack !== 4'b0000) begin failures++; $display("FAIL sb_release got=%b/%b exp=0/0000", bus.fifo_write_en, bus.ack); end
    tick();
    @(negedge clk);
    checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL sb_idle got=%b/%b exp=0000/0", bus.grant, bus.busy); end
    tick();
  endtask

  task automatic test_fairness();
    int wr;
    int own;
    logic exp_we;
    apply_reset();
    for (int i = 0; i < NR; i++) pdata[i] = 8'(i * 16);
    drive_data();
    bus.req = 4'b1111;
    wr = 0;
    for (int c = 0; c < 22; c++) begin
      exp_we = (c % 5) != 0;
      own = (c / 5) % 4;
      @(negedge clk);
      checks++; if (bus.fifo_write_en !== exp_we) begin failures++; $display("FAIL fair_we c=%0d got=%b exp=%b", c, bus.fifo_write_en, exp_we); end
      if (exp_we) begin
        checks++; if (bus.ack !== (4'b0001 << own)) begin failures++; $display("FAIL fair_ack c=%0d got=%b exp=%b", c, bus.ack, 4'b0001 << own); end
        checks++; if (bus.fifo_data_in !== pdata[own]) begin failures++; $display("FAIL fair_data c=%0d got=%h exp=%h", c, bus.fifo_data_in, pdata[own]); end
        pdata[own] = pdata[own] + 8'd1;
      end
      if (bus.fifo_write_en === 1'b1 && c < 20) wr++;
      tick();
      drive_data();
    end
    checks++; if (wr !== 16) begin failures++; $display("FAIL fair_count got=%0d exp=16", wr); end
    bus.req = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_g [10];
    logic       exp_w [10];
    logic       full_v [10];
    int         own;
    exp_g  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2};
    exp_w  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    full_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    apply_reset();
    pdata[0] = 8'h30;
    pdata[1] = 8'h40;
    drive_data();
    bus.req = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      bus.fifo_full = full_v[c];
      own = (c == 9) ? 1 : 0;
      @(negedge clk);
      checks++; if (bus.grant !== exp_g[c]) begin failures++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, bus.grant, exp_g[c]); end
      checks++; if (bus.fifo_write_en !== exp_w[c]) begin failures++; $display("FAIL bp_we c=%0d got=%b exp=%b", c, bus.fifo_write_en, exp_w[c]); end
      checks++; if (bus.ack !== (exp_w[c] ? exp_g[c] : 4'b0000)) begin failures++; $display("FAIL bp_ack c=%0d got=%b", c, bus.ack); end
      if (exp_w[c]) begin
        checks++; if (bus.fifo_data_in !== pdata[own]) begin failures++; $display("FAIL bp_data c=%0d got=%h exp=%h", c, bus.fifo_data_in, pdata[own]); end
        pdata[own] = pdata[own] + 8'd1;
      end
      tick();
      drive_data();
    end
    bus.fifo_full = 1'b0;
    bus.req = '0;
  endtask

  task automatic test_early_drop();
    logic [3:0] req_v [6];
    logic [3:0] exp_g [6];
    logic [3:0] exp_a [6];
    logic [7:0] exp_d [6];
    req_v = '{4'b0100, 4'b1101, 4'b1101, 4'b1001, 4'b1001, 4'b1001};
    exp_g = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
    exp_a = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
    exp_d = '{8'h00, 8'h50, 8'h51, 8'h00, 8'h00, 8'h70};
    apply_reset();
    pdata[0] = 8'h60;
    pdata[2] = 8'h50;
    pdata[3] = 8'h70;
    drive_data();
    for (int c = 0; c < 6; c++) begin
      bus.req = req_v[c];
      @(negedge clk);
      checks++; if (bus.grant !== exp_g[c]) begin failures++; $display("FAIL ed_grant c=%0d got=%b exp=%b", c, bus.grant, exp_g[c]); end
      checks++; if (bus.ack !== exp_a[c]) begin failures++; $display("FAIL ed_ack c=%0d got=%b exp=%b", c, bus.ack, exp_a[c]); end
      checks++; if (bus.fifo_data_in !== exp_d[c]) begin failures++; $display("FAIL ed_data c=%0d got=%h exp=%h", c, bus.fifo_data_in, exp_d[c]); end
      if (exp_a[c] != 4'b0000) pdata[$clog2(exp_a[c])] = pdata[$clog2(exp_a[c])] + 8'd1;
      tick();
      drive_data();
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < NR; i++) pdata[i] = 8'(8'h80 + i);
    drive_data();
    bus.req = 4'b1111;
    tick();
    @(negedge clk);
    checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL rm_beat1 got=%b exp=0001", bus.ack); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.fifo_write_en !== 1'b0 || bus.ack !== 4'b0000) begin failures++; $display("FAIL rm_suppress got=%b/%b exp=0/0000", bus.fifo_write_en, bus.ack); end
    checks++; if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL rm_rst_grant got=%b/%b exp=0000/0", bus.grant, bus.busy); end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.fifo_write_en !== 1'b0 || bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin failures++; $display("FAIL rm_after got=%b/%b/%b exp=0/0000/0", bus.fifo_write_en, bus.grant, bus.busy); end
    tick();
    @(negedge clk);
    checks++; if (bus.grant !== 4'b0001 || bus.fifo_write_en !== 1'b1) begin failures++; $display("FAIL rm_regrant got=%b/%b exp=0001/1", bus.grant, bus.fifo_write_en); end
    tick();
    bus.req = '0;
  endtask

  task automatic test_system();
    logic [7:0] fq [$];
    logic [7:0] wlog [$];
    logic [7:0] rlog [$];
    int  s1, s3, c;
    bit  done;
    logic [7:0] exp_v;
    apply_reset();
    s1 = 0;
    s3 = 0;
    c = 0;
    done = 1'b0;
    while (!done && c < 200) begin
      bus.fifo_full = (fq.size() >= 2);
      bus.req = {(s3 < 4), 1'b0, (s1 < 4), 1'b0};
      pdata[1] = 8'(8'h10 + s1);
      pdata[3] = 8'(8'h20 + s3);
      drive_data();
      @(negedge clk);
      if (bus.fifo_write_en === 1'b1) begin
        checks++; if (bus.fifo_full) begin failures++; $display("FAIL sys_overflow c=%0d got=write exp=nowrite", c); end
        exp_v = bus.ack[1] ? pdata[1] : pdata[3];
        checks++; if (!(bus.ack == 4'b0010 || bus.ack == 4'b1000) || bus.fifo_data_in !== exp_v) begin failures++; $display("FAIL sys_ack c=%0d got=%b/%h exp=%h", c, bus.ack, bus.fifo_data_in, exp_v); end
        wlog.push_back(bus.fifo_data_in);
      end
      if (bus.ack[1]) s1++;
      if (bus.ack[3]) s3++;
      if ((c % 3) == 2 && fq.size() > 0) rlog.push_back(fq.pop_front());
      if (bus.fifo_write_en === 1'b1) fq.push_back(bus.fifo_data_in);
      done = (s1 >= 4) && (s3 >= 4) && (fq.size() == 0);
      c++;
      tick();
    end
    bus.req = '0;
    checks++; if (!done) begin failures++; $display("FAIL sys_timeout got=%0d cycles exp=done", c); end
    checks++; if (rlog.size() != 8 || wlog.size() != 8) begin failures++; $display("FAIL sys_count got=%0d/%0d exp=8/8", rlog.size(), wlog.size()); end
    checks++; if (s1 != 4 || s3 != 4) begin failures++; $display("FAIL sys_acks got=%0d/%0d exp=4/4", s1, s3); end
    for (int k = 0; k < 8 && k < rlog.size() && k < wlog.size(); k++) begin
      checks++; if (rlog[k] !== wlog[k]) begin failures++; $display("FAIL sys_order k=%0d got=%h exp=%h", k, rlog[k], wlog[k]); end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) pdata[i] = '0;
    test_reset();
    test_single_beat();
    test_fairness();
    test_backpressure();
    test_early_drop();
    test_reset_mid_burst();
    test_system();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
